// File: rtl/morse_pkg.sv
// Shared types and unit ratios for the Morse playback path.
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MARK,
      ST_GAP,
      ST_LGAP,
      ST_WGAP
   } state_t;

   localparam int unsigned DOT_UNITS        = 1;
   localparam int unsigned DASH_UNITS       = 3;
   localparam int unsigned SYM_GAP_UNITS    = 1;
   localparam int unsigned LETTER_GAP_UNITS = 3;
   localparam int unsigned WORD_GAP_UNITS   = 7;
   localparam int unsigned MAX_SYMS         = 5;
   localparam int unsigned MAX_SPEED_MULT   = 4;

endpackage

// File: rtl/morse_tone_gen.sv
// Tone square-wave phase divider; phase restarts high and toggles every TONE_DIV enabled cycles.
module morse_tone_gen #(
   parameter int unsigned TONE_DIV = 50_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic enable,
   output logic phase
);

   localparam int unsigned DIV_W = $clog2(TONE_DIV + 1);

   logic [DIV_W-1:0] r_div;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         r_div <= '0;
         phase <= 1'b1;
      end else if (enable) begin
         if (r_div == DIV_W'(TONE_DIV - 1)) begin
            r_div <= '0;
            phase <= ~phase;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/morse_player.sv
// Handshaked Morse character player: sequences timed marks and gaps and gates the buzzer tone.
module morse_player
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV = 10_000_000,
   parameter int unsigned TONE_DIV = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       code_valid,
   output logic       code_ready,
   input  logic [2:0] code_len,
   input  logic [4:0] code_bits,
   input  logic [1:0] speed,
   input  logic       abort,
   output logic       beep,
   output logic       tone_on,
   output logic       busy,
   output logic       done,
   output logic [2:0] sym_idx
);

   localparam int unsigned CNT_W = $clog2(WORD_GAP_UNITS * MAX_SPEED_MULT * TICK_DIV);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_unit;
   logic [2:0]       r_len;
   logic [4:0]       r_bits;

   logic [2:0]       w_len_clamp;
   logic [CNT_W-1:0] w_unit_in;
   logic [2:0]       w_next_idx;
   logic [4:0]       w_bits_sh;
   logic             w_phase;

   // Last count value of a state lasting `units` Morse units.
   function automatic logic [CNT_W-1:0] f_last(input int unsigned units,
                                               input logic [CNT_W-1:0] unit);
      return (CNT_W'(units) * unit) - CNT_W'(1);
   endfunction

   function automatic int unsigned f_mark_units(input logic is_dash);
      return is_dash ? DASH_UNITS : DOT_UNITS;
   endfunction

   assign w_len_clamp = (code_len > 3'(MAX_SYMS)) ? 3'(MAX_SYMS) : code_len;
   assign w_unit_in   = CNT_W'(TICK_DIV) * (CNT_W'(speed) + CNT_W'(1));
   assign w_next_idx  = sym_idx + 3'd1;
   assign w_bits_sh   = r_bits >> w_next_idx;

   // Sequencer: r_cnt counts down the cycles left in the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_unit     <= '0;
         r_len      <= '0;
         r_bits     <= '0;
         code_ready <= 1'b1;
         tone_on    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sym_idx    <= '0;
      end else if (abort) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         code_ready <= 1'b1;
         tone_on    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sym_idx    <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               code_ready <= 1'b1;
               busy       <= 1'b0;
               tone_on    <= 1'b0;
               sym_idx    <= '0;
               if (code_valid) begin
                  r_len      <= w_len_clamp;
                  r_bits     <= code_bits;
                  r_unit     <= w_unit_in;
                  code_ready <= 1'b0;
                  busy       <= 1'b1;
                  if (w_len_clamp != 3'd0) begin
                     r_state <= ST_MARK;
                     tone_on <= 1'b1;
                     r_cnt   <= f_last(f_mark_units(code_bits[0]), w_unit_in);
                  end else begin
                     r_state <= ST_WGAP;
                     r_cnt   <= f_last(WORD_GAP_UNITS, w_unit_in);
                  end
               end
            end
            ST_MARK: begin
               if (r_cnt == '0) begin
                  tone_on <= 1'b0;
                  if (sym_idx < (r_len - 3'd1)) begin
                     r_state <= ST_GAP;
                     r_cnt   <= f_last(SYM_GAP_UNITS, r_unit);
                  end else begin
                     r_state <= ST_LGAP;
                     r_cnt   <= f_last(LETTER_GAP_UNITS, r_unit);
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (r_cnt == '0) begin
                  r_state <= ST_MARK;
                  tone_on <= 1'b1;
                  sym_idx <= w_next_idx;
                  r_cnt   <= f_last(f_mark_units(w_bits_sh[0]), r_unit);
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_LGAP, ST_WGAP: begin
               if (r_cnt == '0) begin
                  r_state    <= ST_IDLE;
                  code_ready <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  sym_idx    <= '0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               code_ready <= 1'b1;
               busy       <= 1'b0;
               tone_on    <= 1'b0;
               sym_idx    <= '0;
            end
         endcase
      end
   end

   // Tone phase is held at its restart value whenever no mark is sounding.
   morse_tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone (
      .clk     (clk),
      .rst     (rst),
      .restart (~tone_on),
      .enable  (tone_on),
      .phase   (w_phase)
   );

   assign beep = tone_on & w_phase;

endmodule

// File: tb/tb_morse_player.sv
// Scoreboard bench for morse_player with TICK_DIV=4, TONE_DIV=2.
module tb_morse_player;

   logic       clk;
   logic       rst;
   logic       code_valid;
   logic       code_ready;
   logic [2:0] code_len;
   logic [4:0] code_bits;
   logic [1:0] speed;
   logic       abort;
   logic       beep;
   logic       tone_on;
   logic       busy;
   logic       done;
   logic [2:0] sym_idx;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string name;
      int    busy_cyc;
      int    tone_cyc;
      int    beep_cyc;
      int    max_sym;
   } exp_t;

   exp_t exp_q[$];

   morse_player #(
      .TICK_DIV (4),
      .TONE_DIV (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code_len   (code_len),
      .code_bits  (code_bits),
      .speed      (speed),
      .abort      (abort),
      .beep       (beep),
      .tone_on    (tone_on),
      .busy       (busy),
      .done       (done),
      .sym_idx    (sym_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: accumulate per-character activity and score it when done pulses.
   int m_busy = 0, m_tone = 0, m_beep = 0, m_max = 0;
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_busy_cycles"}, m_busy, e.busy_cyc);
            check({e.name, "_tone_cycles"}, m_tone, e.tone_cyc);
            check({e.name, "_beep_cycles"}, m_beep, e.beep_cyc);
            check({e.name, "_max_sym_idx"}, m_max, e.max_sym);
         end
         m_busy = 0; m_tone = 0; m_beep = 0; m_max = 0;
      end else if (!busy) begin
         m_busy = 0; m_tone = 0; m_beep = 0; m_max = 0;
      end else begin
         m_busy++;
         if (tone_on) m_tone++;
         if (beep) m_beep++;
         if (int'(sym_idx) > m_max) m_max = int'(sym_idx);
      end
   end

   task automatic push(input string name, input int b, input int t, input int bp, input int ms);
      exp_t e;
      e.name = name; e.busy_cyc = b; e.tone_cyc = t; e.beep_cyc = bp; e.max_sym = ms;
      exp_q.push_back(e);
   endtask

   // Offer one character for a single edge; returns at the negedge of cycle 1.
   task automatic send(input logic [2:0] len, input logic [4:0] bits, input logic [1:0] spd);
      code_valid = 1'b1;
      code_len   = len;
      code_bits  = bits;
      speed      = spd;
      @(negedge clk);
      code_valid = 1'b0;
   endtask

   // Count cycles after accept until done, bounded.
   task automatic wait_done(input int start, output int n);
      n = start;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_code_ready"}, int'(code_ready), 1);
      check({tag, "_busy"},       int'(busy), 0);
      check({tag, "_tone_on"},    int'(tone_on), 0);
      check({tag, "_beep"},       int'(beep), 0);
      check({tag, "_sym_idx"},    int'(sym_idx), 0);
   endtask

   initial begin
      int         n;
      logic [3:0] pat;
      bit         seen;

      rst = 1'b1; code_valid = 1'b0; code_len = '0; code_bits = '0; speed = '0; abort = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset_done", int'(done), 0);
      rst = 1'b0;
      @(negedge clk);

      // 'A': dot, gap, dash, letter gap
      check("a_ready_before", int'(code_ready), 1);
      push("a", 32, 16, 8, 1);
      send(3'd2, 5'b00010, 2'd0);
      check("a_busy_c1", int'(busy), 1);
      check("a_ready_c1", int'(code_ready), 0);
      pat = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("a_mark_tone_%0d", i), int'(tone_on), 1);
         check($sformatf("a_mark_beep_%0d", i), int'(beep), int'(pat[i]));
         @(negedge clk);
      end
      check("a_gap_tone", int'(tone_on), 0);
      repeat (4) @(negedge clk);
      check("a_dash_tone", int'(tone_on), 1);
      check("a_dash_sym", int'(sym_idx), 1);
      wait_done(9, n);
      check("a_done_cycle", n, 33);

      // Word space then back-to-back 'E' on the done cycle
      push("wspace", 28, 0, 0, 0);
      send(3'd0, 5'b00000, 2'd0);
      wait_done(1, n);
      check("wspace_done_cycle", n, 29);
      push("e_b2b", 16, 4, 2, 0);
      check("b2b_ready_on_done", int'(code_ready), 1);
      send(3'd1, 5'b00000, 2'd0);
      check("b2b_mark_tone", int'(tone_on), 1);
      check("b2b_mark_busy", int'(busy), 1);
      wait_done(1, n);
      check("b2b_done_cycle", n, 17);

      // len=7 clamps to 5 dashes; mid-play offer ignored
      push("clamp5", 88, 60, 30, 4);
      send(3'd7, 5'b11111, 2'd0);
      repeat (29) @(negedge clk);
      check("clamp_ready_midplay", int'(code_ready), 0);
      code_valid = 1'b1; code_len = 3'd1; code_bits = 5'b00000;
      @(negedge clk);
      code_valid = 1'b0;
      wait_done(31, n);
      check("clamp_done_cycle", n, 89);

      // speed=1 'E'; later input changes have no effect
      push("e_speed1", 32, 8, 4, 0);
      send(3'd1, 5'b00000, 2'd1);
      repeat (3) @(negedge clk);
      speed = 2'd3; code_bits = 5'b11111; code_len = 3'd5;
      wait_done(4, n);
      check("speed1_done_cycle", n, 33);
      speed = '0; code_bits = '0; code_len = '0;
      @(negedge clk);

      // Abort on cycle 6 of a dash
      send(3'd1, 5'b00001, 2'd0);
      repeat (5) @(negedge clk);
      check("abort_pre_tone", int'(tone_on), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort");
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("abort_no_done", int'(seen), 0);

      // Abort wins over a coincident accept
      code_valid = 1'b1; code_len = 3'd1; code_bits = 5'b00001; abort = 1'b1;
      @(negedge clk);
      code_valid = 1'b0; abort = 1'b0;
      check_idle("abort_accept");
      @(negedge clk);
      check("abort_accept_later_busy", int'(busy), 0);

      // Reset mid-MARK
      send(3'd1, 5'b00001, 2'd0);
      repeat (2) @(negedge clk);
      check("rst_pre_tone", int'(tone_on), 1);
      rst = 1'b1;
      @(negedge clk);
      check_idle("rst_mid");
      check("rst_mid_done", int'(done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/morse_player.md
# morse_player

Downstream playback stage for the Morse encoder path. It accepts one encoded character per valid/ready handshake, as a symbol count plus a dot/dash bit vector. It then plays the character as timed tone marks and silent gaps on the buzzer output, using standard Morse unit ratios scaled by a speed select. It replaces free-running switch-shift sequencing with a deterministic, handshaked sequencer.

## Interface
- `TICK_DIV`, default 10_000_000: clock cycles per Morse unit at speed 0.
- `TONE_DIV`, default 50_000: clock cycles per half-period of the tone square wave.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `code_valid`  in  1: character offered.
- `code_ready`  out  1: block can accept a character; high only in IDLE.
- `code_len`  in  3: symbol count; 0 means word space; values above 5 are clamped to 5.
- `code_bits`  in  5: symbol i = `code_bits[i]` (1 = dash, 0 = dot); bit 0 is played first.
- `speed`  in  2: unit length = `TICK_DIV*(speed+1)` cycles.
- `abort`  in  1: stop playback immediately.
- `beep`  out  1: gated square wave to the buzzer pin.
- `tone_on`  out  1: mark envelope.
- `busy`  out  1: not IDLE.
- `done`  out  1: one-cycle pulse when a character or word space finishes. Not pulsed on abort.
- `sym_idx`  out  3: index of the symbol currently playing; 0 in IDLE.

## Operation
- States: IDLE, MARK, GAP, LGAP, WGAP.
- IDLE + `code_valid` → latch len (clamped), bits and speed; this is the accept edge.
  - len > 0 → MARK with `sym_idx` = 0.
  - len = 0 → WGAP.
- MARK lasts 1 unit (dot) or 3 units (dash). At the end:
  - `sym_idx` < len−1 → GAP.
  - otherwise → LGAP.
- GAP lasts 1 unit, then `sym_idx`+1 and → MARK.
- LGAP lasts 3 units → IDLE with `done`.
- WGAP lasts 7 units → IDLE with `done`.
- Inputs changing after accept have no effect. `code_valid` outside IDLE is ignored; there is no queueing.
- `abort` returns to IDLE on the next edge with `beep`/`tone_on` low. It has priority over every transition, including a coincident accept.
- `rst` has priority over `abort`.
- Duration counter width: ceil(log2(7·4·TICK_DIV)) bits minimum; no wrap within WGAP at speed 3.
- Tone: a phase bit is forced to 1 on the first cycle of every MARK and toggles every TONE_DIV cycles. `beep` = `tone_on` & phase.

## Timing
- Reset values: `code_ready`=1, `busy`=0, `tone_on`=0, `beep`=0, `done`=0, `sym_idx`=0, state IDLE.
- Accept at edge T:
  - `busy`=1 and `code_ready`=0 from T+1.
  - For a MARK, `tone_on`=1 from T+1.
- Each state occupies exactly units·U cycles, where U = `TICK_DIV*(speed+1)`, with no idle cycles between states.
- `done` is high on the first IDLE cycle. `code_ready` is also high that cycle, so a back-to-back accept on that edge is legal with zero dead time.
- Total busy cycles for a character = U·(Σmark units + (len−1) + 3).
- `abort` asserted at edge T gives IDLE outputs from T+1.

## Structure
- `morse_pkg`:
  - state enum.
  - Constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7, MAX_SYMS=5.
- Sub-module `morse_tone_gen`:
  - Tone phase divider with restart and enable.
  - Instantiated once.
- Sequencer and duration counter live in `morse_player`.

## Test plan
All scenarios use `TICK_DIV`=4 and `TONE_DIV`=2.
- Reset → `code_ready`=1, all other outputs 0. Send 'A' (len=2, bits=5'b00010, speed=0) → `tone_on` high 4 cycles, low 4, high 12, low 12. `done` on cycle 33 after accept. Busy for 32 cycles.
- Beep waveform during the first MARK of 'A' → `beep` = 1,1,0,0 relative to the MARK start.
- Word space (len=0) → 28 cycles silent, `done` on cycle 29. Back-to-back 'E' (len=1, bits=0) accepted on the `done` cycle → MARK starts the next cycle.
- len=7, bits=5'b11111 → clamped to 5 dashes: 5·12 + 4·4 + 12 = 88 busy cycles, `sym_idx` steps 0..4. `code_valid` pulsed mid-play → ignored.
- speed=1, 'E' → 8-cycle mark plus 24-cycle letter gap. Changing `speed` to 3 mid-play → no effect.
- `abort` on cycle 6 of a dash → `tone_on`/`beep` low next cycle, IDLE, no `done`. `rst` asserted mid-MARK → reset values on the next edge.
